// File: rtl/dpi_stream_sequencer.sv
// DPI matcher front end: maps flow keys to 6-bit stream ids and sequences load_state / chars / eop.
// Optional DPI_SEQ_ERR_CNT_EN adds err_cnt counting dropped non-sop beats and truncated packets.
module dpi_stream_sequencer #(
   parameter int KEY_W     = 16,
   parameter int NUM_REGEX = 8,
   parameter int LOAD_GAP  = 2,
   parameter int EOP_GAP   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [7:0]           in_data,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic [KEY_W-1:0]     in_flow_key,
   input  logic [NUM_REGEX-1:0] in_enable,
   input  logic                 flush,
   output logic [7:0]           char_in,
   output logic                 char_in_vld,
   output logic                 load_state,
   output logic [5:0]           stream_id,
   output logic                 new_stream_id,
   output logic                 eop,
   output logic [NUM_REGEX-1:0] enable,
   output logic                 busy,
   output logic                 table_full
`ifdef DPI_SEQ_ERR_CNT_EN
   ,
   output logic [15:0]          err_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP
   } state_e;

   state_e                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [KEY_W-1:0]       key_q;
   logic [KEY_W-1:0]       key_tab_q [64];
   logic [63:0]            valid_q;
   logic [6:0]             free_ptr_q;
   logic [5:0]             rr_ptr_q;
   logic                   flush_pend_q;
   logic                   first_q;
   logic                   fresh_q;
   logic [5:0]             stream_id_q;
   logic [NUM_REGEX-1:0]   enable_q;
   logic                   load_q, new_q, eop_q, busy_q, char_vld_q;
   logic [7:0]             char_q;

   logic [63:0]            hit_vec;
   logic                   hit;
   logic [5:0]             hit_idx, alloc_idx;
   logic                   full_w;
   logic                   accept_sop, do_flush, take, trunc;

   for (genvar gi = 0; gi < 64; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_q[gi] && (key_tab_q[gi] == key_q);
   end

   // Entries are allocated in index order and only ever cleared all at once,
   // so the free pointer is always the lowest free index.
   assign full_w = free_ptr_q[6];
   assign hit    = |hit_vec;

   always_comb begin
      hit_idx = '0;
      for (int i = 63; i >= 0; i--) begin
         if (hit_vec[i]) hit_idx = 6'(i);
      end
      alloc_idx = hit ? hit_idx : (full_w ? rr_ptr_q : free_ptr_q[5:0]);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_rdy     = 1'b0;
      accept_sop = 1'b0;
      do_flush   = 1'b0;
      take       = 1'b0;
      trunc      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_rdy = in_vld & ~in_sop;
            if (flush | flush_pend_q) begin
               do_flush = 1'b1;
            end else if (in_vld & in_sop) begin
               accept_sop = 1'b1;
               state_d    = S_LOOKUP;
            end
         end
         S_LOOKUP: state_d = S_LOAD;
         S_LOAD: begin
            state_d = S_GAP;
            cnt_d   = 8'(LOAD_GAP - 2);
         end
         S_GAP: begin
            if (cnt_q == 8'd0) state_d = S_STREAM;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_STREAM: begin
            // The packet's own sop beat is still pending on the first beat; any later sop truncates.
            trunc  = in_vld & in_sop & ~first_q;
            in_rdy = ~trunc;
            cnt_d  = 8'(EOP_GAP - 1);
            if (trunc) begin
               state_d = S_DRAIN;
            end else if (in_vld) begin
               take = 1'b1;
               if (in_eop) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cnt_q == 8'd0) state_d = S_EOP;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_EOP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         key_q        <= '0;
         valid_q      <= '0;
         free_ptr_q   <= '0;
         rr_ptr_q     <= '0;
         flush_pend_q <= 1'b0;
         first_q      <= 1'b0;
         fresh_q      <= 1'b0;
         stream_id_q  <= '0;
         enable_q     <= '0;
         load_q       <= 1'b0;
         new_q        <= 1'b0;
         eop_q        <= 1'b0;
         busy_q       <= 1'b0;
         char_vld_q   <= 1'b0;
         char_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         load_q     <= (state_q == S_LOAD);
         new_q      <= (state_q == S_LOAD) & fresh_q;
         eop_q      <= (state_q == S_EOP);
         busy_q     <= (state_q != S_IDLE);
         char_vld_q <= take;
         if (take) begin
            char_q  <= in_data;
            first_q <= 1'b0;
         end
         if (accept_sop) begin
            key_q    <= in_flow_key;
            enable_q <= in_enable;
            first_q  <= 1'b1;
         end
         if (do_flush)   flush_pend_q <= 1'b0;
         else if (flush) flush_pend_q <= 1'b1;
         if (do_flush) begin
            valid_q    <= '0;
            free_ptr_q <= '0;
            rr_ptr_q   <= '0;
         end
         if (state_q == S_LOOKUP) begin
            stream_id_q <= alloc_idx;
            fresh_q     <= ~hit;
            if (!hit) begin
               valid_q[alloc_idx] <= 1'b1;
               if (full_w) rr_ptr_q   <= rr_ptr_q + 6'd1;
               else        free_ptr_q <= free_ptr_q + 7'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_LOOKUP && !hit) key_tab_q[alloc_idx] <= key_q;
   end

`ifdef DPI_SEQ_ERR_CNT_EN
   logic [15:0] err_q;
   logic        err_evt;
   assign err_evt = (state_q == S_IDLE && in_vld && !in_sop) || trunc;

   always_ff @(posedge clk) begin
      if (!rst_n)                            err_q <= '0;
      else if (err_evt && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
   end
   assign err_cnt = err_q;
`endif

   assign char_in       = char_q;
   assign char_in_vld   = char_vld_q;
   assign load_state    = load_q;
   assign stream_id     = stream_id_q;
   assign new_stream_id = new_q;
   assign eop           = eop_q;
   assign enable        = enable_q;
   assign busy          = busy_q;
   assign table_full    = full_w;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Bench for dpi_stream_sequencer: directed flow-table / timing cases, then random packets
// checked against a packet-level flow-table model and observed output event queues.
`timescale 1ns/1ps
module tb_dpi_stream_sequencer;
   localparam int LOAD_GAP = 2;
   localparam int EOP_GAP  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [7:0]  in_data = '0;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic [15:0] in_flow_key = '0;
   logic [7:0]  in_enable = '0;
   logic        flush = 1'b0;
   logic [7:0]  char_in;
   logic        char_in_vld;
   logic        load_state;
   logic [5:0]  stream_id;
   logic        new_stream_id;
   logic        eop;
   logic [7:0]  enable;
   logic        busy;
   logic        table_full;
`ifdef DPI_SEQ_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   always #5 clk = ~clk;

   dpi_stream_sequencer #(.KEY_W(16), .NUM_REGEX(8), .LOAD_GAP(LOAD_GAP), .EOP_GAP(EOP_GAP)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop), .in_flow_key(in_flow_key), .in_enable(in_enable),
      .flush(flush), .char_in(char_in), .char_in_vld(char_in_vld), .load_state(load_state),
      .stream_id(stream_id), .new_stream_id(new_stream_id), .eop(eop), .enable(enable),
      .busy(busy), .table_full(table_full)
`ifdef DPI_SEQ_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output event capture
   typedef struct {int cyc; logic [5:0] id; logic nw; logic [7:0] en;} ld_t;
   typedef struct {int cyc; logic [7:0] c;} ch_t;
   typedef struct {int cyc; logic [5:0] id;} ep_t;
   ld_t ld_q[$];
   ch_t ch_q[$];
   ep_t ep_q[$];
   ld_t mon_l;
   ch_t mon_c;
   ep_t mon_e;
   int  cyc = 0;
   int  excl_err = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (load_state) begin
            mon_l.cyc = cyc; mon_l.id = stream_id; mon_l.nw = new_stream_id; mon_l.en = enable;
            ld_q.push_back(mon_l);
         end
         if (char_in_vld) begin
            mon_c.cyc = cyc; mon_c.c = char_in;
            ch_q.push_back(mon_c);
         end
         if (eop) begin
            mon_e.cyc = cyc; mon_e.id = stream_id;
            ep_q.push_back(mon_e);
         end
         if (int'(load_state) + int'(char_in_vld) + int'(eop) > 1) excl_err++;
      end
   end

   // Flow table model: key -> id, lowest free on miss, round-robin eviction when full
   logic [15:0] m_key [64];
   logic        m_val [64];
   int          m_rr = 0;

   task automatic m_lookup(input logic [15:0] k, output logic [5:0] id, output logic nw);
      int free_i;
      free_i = -1;
      id = '0;
      nw = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (m_val[i] && m_key[i] == k) begin id = 6'(i); nw = 1'b0; end
      end
      if (nw) begin
         for (int i = 63; i >= 0; i--) if (!m_val[i]) free_i = i;
         if (free_i >= 0) id = 6'(free_i);
         else begin id = 6'(m_rr); m_rr = (m_rr + 1) % 64; end
         m_key[id] = k;
         m_val[id] = 1'b1;
      end
   endtask

   task automatic m_flush();
      for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
      m_rr = 0;
   endtask

   // Packet payload and per-beat idle cycles inserted before each beat
   logic [7:0] pd [16];
   int         pb [16];

   task automatic drive_beat(input logic [7:0] d, input logic sop, input logic last,
                             input logic [15:0] key, input logic [7:0] en);
      int n;
      n = 0;
      in_vld = 1'b1; in_data = d; in_sop = sop; in_eop = last; in_flow_key = key; in_enable = en;
      @(negedge clk);
      while (!in_rdy && n < 300) begin @(negedge clk); n++; end
      check_val("in_rdy", in_rdy, 1);
      @(posedge clk); #1;
      in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic send_beats(input logic [15:0] key, input logic [7:0] en,
                             input int from, input int to, input logic last_eop);
      for (int i = from; i < to; i++) begin
         if (pb[i] > 0) begin
            repeat (pb[i]) @(posedge clk);
            #1;
         end
         drive_beat(pd[i], i == 0, last_eop && (i == to - 1), key, en);
      end
   endtask

   task automatic verify_pkt(input string tag, input logic [15:0] key, input logic [5:0] eid,
                             input logic enw, input logic [7:0] een, input int n, input logic trunc);
      int  w, nc, last;
      ld_t l;
      ep_t e;
      ch_t c;
      w = 0; nc = 0; last = 0;
      while (ep_q.size() == 0 && w < 400) begin @(negedge clk); w++; end
      check_val({tag, " eop_seen"}, ep_q.size() > 0, 1);
      check_val({tag, " load_seen"}, ld_q.size() > 0, 1);
      if (ep_q.size() == 0 || ld_q.size() == 0) return;
      l = ld_q.pop_front();
      e = ep_q.pop_front();
      check_val({tag, " stream_id"}, l.id, eid);
      check_val({tag, " new_stream_id"}, l.nw, enw);
      check_val({tag, " enable"}, l.en, een);
      check_val({tag, " eop_stream_id"}, e.id, eid);
      while (ch_q.size() > 0 && ch_q[0].cyc < e.cyc) begin
         c = ch_q.pop_front();
         if (nc < n) check_val({tag, " char"}, c.c, pd[nc]);
         if (nc == 0)     check_val({tag, " load_to_char"}, c.cyc - l.cyc, LOAD_GAP);
         else if (nc < n) check_val({tag, " char_gap"}, c.cyc - last, pb[nc] + 1);
         last = c.cyc;
         nc++;
      end
      check_val({tag, " nchars"}, nc, n);
      if (!trunc) check_val({tag, " char_to_eop"}, e.cyc - last, EOP_GAP + 1);
      check_val({tag, " exclusive"}, excl_err, 0);
      $display("pkt %-10s key=%h id=%0d new=%0d chars=%0d eop@%0d", tag, key, l.id, l.nw, nc, e.cyc);
   endtask

   task automatic run_pkt(input string tag, input logic [15:0] key, input logic [7:0] en, input int n);
      logic [5:0] id;
      logic       nw;
      m_lookup(key, id, nw);
      send_beats(key, en, 0, n, 1'b1);
      verify_pkt(tag, key, id, nw, en, n, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: no finish by time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ida, idb;
      logic       nwa, nwb;
      int         n;
      for (int i = 0; i < 64; i++) begin m_val[i] = 1'b0; m_key[i] = '0; end
      for (int i = 0; i < 16; i++) begin pd[i] = '0; pb[i] = 0; end

      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("rst load_state", load_state, 0);
      check_val("rst char_in_vld", char_in_vld, 0);
      check_val("rst eop", eop, 0);
      check_val("rst busy", busy, 0);
      check_val("rst table_full", table_full, 0);
      check_val("rst stream_id", stream_id, 0);
      check_val("rst new_stream_id", new_stream_id, 0);
      check_val("rst enable", enable, 0);
      check_val("rst in_rdy", in_rdy, 0);
`ifdef DPI_SEQ_ERR_CNT_EN
      check_val("rst err_cnt", err_cnt, 0);
`endif

      pd[0] = 8'h41; pd[1] = 8'h42; pd[2] = 8'h43;
      run_pkt("abc", 16'h1234, 8'hFF, 3);
      run_pkt("abc_hit", 16'h1234, 8'h0F, 3);
      run_pkt("k5678", 16'h5678, 8'hA5, 2);

      for (int i = 0; i < 62; i++) begin
         pd[0] = 8'(i);
         run_pkt("fill", 16'(16'h1000 + i), 8'(i), 1);
      end
      @(negedge clk);
      check_val("table_full", table_full, 1);
      run_pkt("evict0", 16'hBEEF, 8'h01, 1);
      run_pkt("evict1", 16'hCAFE, 8'h02, 1);
      run_pkt("old_miss", 16'h1234, 8'h03, 1);

      pd[0] = 8'h10; pd[1] = 8'h11; pd[2] = 8'h12; pd[3] = 8'h13; pb[2] = 3;
      run_pkt("bubble", 16'h7777, 8'h5A, 4);
      pb[2] = 0;

      // Second packet's sop arrives after two beats of the first
      pd[0] = 8'h61; pd[1] = 8'h62; pd[2] = 8'h63;
      m_lookup(16'hAAAA, ida, nwa);
      send_beats(16'hAAAA, 8'h11, 0, 2, 1'b0);
      m_lookup(16'hBBBB, idb, nwb);
      send_beats(16'hBBBB, 8'h22, 0, 3, 1'b1);
      verify_pkt("trunc_a", 16'hAAAA, ida, nwa, 8'h11, 2, 1'b1);
      verify_pkt("trunc_b", 16'hBBBB, idb, nwb, 8'h22, 3, 1'b0);
`ifdef DPI_SEQ_ERR_CNT_EN
      check_val("err_cnt trunc", err_cnt, 1);
`endif

      drive_beat(8'h55, 1'b0, 1'b0, 16'h0000, 8'h00);
      repeat (6) @(negedge clk);
      check_val("drop no_load", ld_q.size(), 0);
      check_val("drop busy", busy, 0);
`ifdef DPI_SEQ_ERR_CNT_EN
      check_val("err_cnt drop", err_cnt, 2);
`endif

      // Flush pulse coincides with the third beat
      pd[0] = 8'h71; pd[1] = 8'h72; pd[2] = 8'h73; pd[3] = 8'h74;
      m_lookup(16'hBBBB, ida, nwa);
      send_beats(16'hBBBB, 8'h33, 0, 2, 1'b0);
      flush = 1'b1;
      fork
         begin @(posedge clk); #1 flush = 1'b0; end
      join_none
      send_beats(16'hBBBB, 8'h33, 2, 4, 1'b1);
      verify_pkt("flush_pkt", 16'hBBBB, ida, nwa, 8'h33, 4, 1'b0);
      m_flush();
      @(negedge clk);
      check_val("flush table_full", table_full, 0);
      run_pkt("post_flush", 16'hBBBB, 8'h44, 2);

      for (int p = 0; p < 40; p++) begin
         n = int'($urandom_range(1, 5));
         for (int i = 0; i < n; i++) begin
            pd[i] = 8'($urandom);
            pb[i] = (i == 0) ? 0 : int'($urandom_range(0, 2));
         end
         run_pkt("rand", 16'(16'h2000 + $urandom_range(0, 9)), 8'($urandom), n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
